mbist_march_ctrl: RTL and testbench

- March C- BIST engine sitting directly upstream of the fault memory model.
- Generates the memory's write_read/address/wdata stream and checks returned rdata against expected values.
- Reports pass/fail, first failing address and first failing march element to the top-level BIST wrapper.
- Honours the memory's timing: write data captured one cycle before the write, and read data returned two cycles after the read is issued.

---
 rtl/mbist_march_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// mbist_march_ctrl
//
// March C- memory BIST engine. It drives the write_read/address/wdata stream
// of the memory under test and checks the returned read data.
//
// Memory timing:
//   - write data is presented one cycle ahead of its write
//   - read data comes back two cycles after the read is issued
//
// Ports
//   clk            system clock, all logic on posedge
//   rst_n          synchronous active-low reset
//   start          one-cycle pulse, accepted only in IDLE
//   busy           high from the cycle after start until the done cycle
//   done           one-cycle pulse at end of run
//   fail           sticky mismatch flag, cleared at start
//   fail_addr      address of the first mismatch
//   fail_elem      march element (0..5) of the first mismatch
//   fail_pass      (MBIST_CKBD_EN only) 0 = solid pass, 1 = checkerboard
//                  pass, for the first mismatch
//   mem_write_read 1 = write, 0 = read
//   mem_address    memory address
//   mem_wdata      memory write data, leads its write by one cycle
//   mem_rdata      memory read data
//
// Optional feature macro: MBIST_CKBD_EN
//   When defined, a second March C- pass follows the solid pass using a
//   01-repeating checkerboard background. The two passes run back to back
//   with no done pulse between them.
// ---------------------------------------------------------------------------
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_ADDR  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
`ifdef MBIST_CKBD_EN
  output logic                  fail_pass,
`endif
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(LAST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;

  // Pointer to the op that will be issued on the next RUN cycle.
  logic [2:0]            nxt_elem_q;
  logic [ADDR_WIDTH-1:0] nxt_addr_q;
  logic                  nxt_ph_q;
  // Set once the pointer has moved past the final op of the pass.
  logic                  end_q;
  logic                  drain_cnt;

  // Attributes of the op currently on the memory bus.
  logic                  cur_rd_q;
  logic [DATA_WIDTH-1:0] cur_exp_q;
  logic [2:0]            cur_elem_q;

  // Pass selector: 0 = solid background, 1 = checkerboard background.
  logic                  pass_q;
`ifndef MBIST_CKBD_EN
  assign pass_q = 1'b0;
`endif

  // Read-check pipe, aligned with the two-cycle read latency.
  logic                  vld_p1, vld_p2;
  logic [DATA_WIDTH-1:0] exp_p1, exp_p2;
  logic [ADDR_WIDTH-1:0] addr_p1, addr_p2;
  logic [2:0]            elem_p1, elem_p2;
`ifdef MBIST_CKBD_EN
  logic                  pass_p1, pass_p2;
`endif

  // -------------------------------------------------------------------------
  // March C- op table helpers
  // -------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] bg_of(input logic p);
    bg_of = p ? DATA_WIDTH'({(DATA_WIDTH/2){2'b01}}) : '0;
  endfunction

  // E0 and E5 have a single op per address; E1..E4 have read then write.
  function automatic logic elem_two_ops(input logic [2:0] e);
    elem_two_ops = (e != 3'd0) && (e != 3'd5);
  endfunction

  function automatic logic elem_down(input logic [2:0] e);
    elem_down = (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic op_is_write(input logic [2:0] e, input logic ph);
    if (e == 3'd0)      op_is_write = 1'b1;
    else if (e == 3'd5) op_is_write = 1'b0;
    else                op_is_write = ph;
  endfunction

  // Data of an op: write data for writes, expected read data for reads.
  function automatic logic [DATA_WIDTH-1:0] op_data(input logic [2:0] e,
                                                    input logic ph,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic inv;
    if ((e == 3'd1) || (e == 3'd3))      inv = ph;
    else if ((e == 3'd2) || (e == 3'd4)) inv = !ph;
    else                                 inv = 1'b0;
    op_data = inv ? ~b : b;
  endfunction

  logic [DATA_WIDTH-1:0] bg;
  assign bg = bg_of(pass_q);

  // -------------------------------------------------------------------------
  // Next-op pointer advance
  // -------------------------------------------------------------------------
  logic [2:0]            adv_elem;
  logic [ADDR_WIDTH-1:0] adv_addr;
  logic                  adv_ph;
  logic                  adv_last;

  always_comb begin
    adv_elem = nxt_elem_q;
    adv_addr = nxt_addr_q;
    adv_ph   = 1'b0;
    adv_last = 1'b0;
    if (elem_two_ops(nxt_elem_q) && !nxt_ph_q) begin
      adv_ph = 1'b1;
    end else if (elem_down(nxt_elem_q)) begin
      if (nxt_addr_q == '0) begin
        adv_elem = nxt_elem_q + 3'd1;
        adv_addr = elem_down(nxt_elem_q + 3'd1) ? ADDR_TOP : '0;
      end else begin
        adv_addr = nxt_addr_q - 1'b1;
      end
    end else begin
      if (nxt_addr_q == ADDR_TOP) begin
        if (nxt_elem_q == 3'd5) begin
          adv_last = 1'b1;
          adv_elem = 3'd0;
          adv_addr = '0;
        end else begin
          adv_elem = nxt_elem_q + 3'd1;
          adv_addr = elem_down(nxt_elem_q + 3'd1) ? ADDR_TOP : '0;
        end
      end else begin
        adv_addr = nxt_addr_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs and first-fail capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      fail_addr      <= '0;
      fail_elem      <= '0;
      mem_write_read <= 1'b0;
      mem_address    <= '0;
      mem_wdata      <= '0;
      nxt_elem_q     <= '0;
      nxt_addr_q     <= '0;
      nxt_ph_q       <= 1'b0;
      end_q          <= 1'b0;
      drain_cnt      <= 1'b0;
      cur_rd_q       <= 1'b0;
      cur_exp_q      <= '0;
      cur_elem_q     <= '0;
`ifdef MBIST_CKBD_EN
      pass_q         <= 1'b0;
      fail_pass      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_PRELOAD;
            busy           <= 1'b1;
            fail           <= 1'b0;
            fail_addr      <= '0;
            fail_elem      <= '0;
`ifdef MBIST_CKBD_EN
            pass_q         <= 1'b0;
            fail_pass      <= 1'b0;
`endif
            nxt_elem_q     <= '0;
            nxt_addr_q     <= '0;
            nxt_ph_q       <= 1'b0;
            end_q          <= 1'b0;
            cur_rd_q       <= 1'b0;
            mem_write_read <= 1'b0;
            mem_address    <= '0;
            mem_wdata      <= bg_of(1'b0);
          end
        end

        S_PRELOAD, S_RUN: begin
          if ((state == S_RUN) && end_q) begin
            state          <= S_DRAIN;
            mem_write_read <= 1'b0;
            cur_rd_q       <= 1'b0;
            drain_cnt      <= 1'b0;
          end else begin
            // Issue the pointed op and preload the data of the op after it.
            state          <= S_RUN;
            mem_write_read <= op_is_write(nxt_elem_q, nxt_ph_q);
            mem_address    <= nxt_addr_q;
            cur_rd_q       <= !op_is_write(nxt_elem_q, nxt_ph_q);
            cur_exp_q      <= op_data(nxt_elem_q, nxt_ph_q, bg);
            cur_elem_q     <= nxt_elem_q;
            nxt_elem_q     <= adv_elem;
            nxt_addr_q     <= adv_addr;
            nxt_ph_q       <= adv_ph;
            end_q          <= adv_last;
            mem_wdata      <= op_data(adv_elem, adv_ph, bg);
          end
        end

        S_DRAIN: begin
          if (drain_cnt) begin
`ifdef MBIST_CKBD_EN
            if (!pass_q) begin
              state       <= S_PRELOAD;
              pass_q      <= 1'b1;
              nxt_elem_q  <= '0;
              nxt_addr_q  <= '0;
              nxt_ph_q    <= 1'b0;
              end_q       <= 1'b0;
              mem_address <= '0;
              mem_wdata   <= bg_of(1'b1);
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
`else
            state <= S_DONE;
            done  <= 1'b1;
`endif
          end else begin
            drain_cnt <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase

      // Only the first mismatch records its location; fail stays sticky.
      if (vld_p2 && (mem_rdata != exp_p2)) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= addr_p2;
          fail_elem <= elem_p2;
`ifdef MBIST_CKBD_EN
          fail_pass <= pass_p2;
`endif
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // p1: read issued last cycle, memory capturing the word
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= cur_rd_q;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    exp_p1  <= cur_exp_q;
    addr_p1 <= mem_address;
    elem_p1 <= cur_elem_q;
`ifdef MBIST_CKBD_EN
    pass_p1 <= pass_q;
`endif
    // -----------------------------------------------------------------------
    // p2: read data valid on mem_rdata, compared this cycle
    // -----------------------------------------------------------------------
    exp_p2  <= exp_p1;
    addr_p2 <= addr_p1;
    elem_p2 <= elem_p1;
`ifdef MBIST_CKBD_EN
    pass_p2 <= pass_p1;
`endif
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
`timescale 1ns/1ps
module tb_mbist_march_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NCYC = 340;
`ifdef MBIST_CKBD_EN
  localparam int DONE_CYC = 327;
  localparam int WR_CNT   = 160;
`else
  localparam int DONE_CYC = 164;
  localparam int WR_CNT   = 80;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
`ifdef MBIST_CKBD_EN
  logic          fail_pass;
`endif
  logic          mem_write_read;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mbist_march_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .LAST_ADDR (15)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .fail_addr     (fail_addr),
    .fail_elem     (fail_elem),
`ifdef MBIST_CKBD_EN
    .fail_pass     (fail_pass),
`endif
    .mem_write_read(mem_write_read),
    .mem_address   (mem_address),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with per-address stuck-at masks: write data registered
  // one cycle ahead, read data returned two cycles after the read.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] sa1 [16];
  logic [DW-1:0] sa0 [16];
  logic [DW-1:0] wd_q;
  logic [DW-1:0] rd1;

  always @(posedge clk) begin
    wd_q <= mem_wdata;
    if (mem_write_read)
      mem[mem_address] <= (wd_q | sa1[mem_address]) & ~sa0[mem_address];
    rd1       <= (mem[mem_address] | sa1[mem_address]) & ~sa0[mem_address];
    mem_rdata <= rd1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected op stream of one solid March C- pass.
  logic       ex_wr   [160];
  logic [3:0] ex_addr [160];
  logic [7:0] ex_wd   [160];
  int         ex_k = 0;

  task automatic add_op(input logic w, input int a, input logic [7:0] d);
    ex_wr[ex_k]   = w;
    ex_addr[ex_k] = 4'(a);
    ex_wd[ex_k]   = d;
    ex_k++;
  endtask

  // Per-cycle trace of the last run, indexed by cycle after start.
  logic       tr_wr   [NCYC+1];
  logic [3:0] tr_addr [NCYC+1];
  logic [7:0] tr_wd   [NCYC+1];

  task automatic set_faults(input int fa0, input logic [7:0] s1a, input logic [7:0] s0a,
                            input int fa1, input logic [7:0] s1b, input logic [7:0] s0b);
    for (int i = 0; i < 16; i++) begin
      sa1[i] = 8'h00;
      sa0[i] = 8'h00;
    end
    if (fa0 >= 0) begin sa1[fa0] = s1a; sa0[fa0] = s0a; end
    if (fa1 >= 0) begin sa1[fa1] = s1b; sa0[fa1] = s0b; end
  endtask

  // Start pulse sampled at edge 0; cycle c is observed at the negedge in it.
  // A stray start at cycle 40 must be ignored.
  task automatic run_once(output int done_cyc, output int done_cnt,
                          output int busy_cnt, output int wr_cnt);
    done_cyc = -1;
    done_cnt = 0;
    busy_cnt = 0;
    wr_cnt   = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk);
      start = (c == 40);
      tr_wr[c]   = mem_write_read;
      tr_addr[c] = mem_address;
      tr_wd[c]   = mem_wdata;
      if (busy) busy_cnt++;
      if (mem_write_read) wr_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    int         fa0;
    logic [7:0] s1a;
    logic [7:0] s0a;
    int         fa1;
    logic [7:0] s1b;
    logic [7:0] s0b;
    logic       e_fail;
    logic [3:0] e_addr;
    logic [2:0] e_elem;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int dc, dn, bc, wc, terr, busy_seen;

    // Fault vectors with hand-derived first failures.
    vecs[0] = '{-1, 8'h00, 8'h00, -1, 8'h00, 8'h00, 1'b0, 4'd0,  3'd0};
    vecs[1] = '{ 5, 8'h01, 8'h00, -1, 8'h00, 8'h00, 1'b1, 4'd5,  3'd1};
    vecs[2] = '{15, 8'h00, 8'h08, -1, 8'h00, 8'h00, 1'b1, 4'd15, 3'd2};
    vecs[3] = '{ 0, 8'h80, 8'h00, -1, 8'h00, 8'h00, 1'b1, 4'd0,  3'd1};
    vecs[4] = '{10, 8'h00, 8'hFF, -1, 8'h00, 8'h00, 1'b1, 4'd10, 3'd2};
    vecs[5] = '{ 9, 8'h10, 8'h00,  2, 8'h02, 8'h00, 1'b1, 4'd2,  3'd1};
    vecs[6] = '{ 3, 8'h55, 8'hAA, -1, 8'h00, 8'h00, 1'b1, 4'd3,  3'd1};
    vecs[7] = '{-1, 8'h00, 8'h00, -1, 8'h00, 8'h00, 1'b0, 4'd0,  3'd0};

    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 16; i++) begin
        int a;
        a = (e == 3 || e == 4) ? 15 - i : i;
        case (e)
          0: add_op(1'b1, a, 8'h00);
          1: begin add_op(1'b0, a, 8'h00); add_op(1'b1, a, 8'hFF); end
          2: begin add_op(1'b0, a, 8'hFF); add_op(1'b1, a, 8'h00); end
          3: begin add_op(1'b0, a, 8'h00); add_op(1'b1, a, 8'hFF); end
          4: begin add_op(1'b0, a, 8'hFF); add_op(1'b1, a, 8'h00); end
          default: add_op(1'b0, a, 8'h00);
        endcase
      end
    end

    set_faults(-1, 8'h00, 8'h00, -1, 8'h00, 8'h00);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({busy, done, fail}), 32'd0);
    chk("reset_fail_loc", 32'({fail_addr, fail_elem}), 32'd0);
    chk("reset_mem_if", 32'({mem_write_read, mem_address, mem_wdata}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      set_faults(vecs[v].fa0, vecs[v].s1a, vecs[v].s0a, vecs[v].fa1, vecs[v].s1b, vecs[v].s0b);
      run_once(dc, dn, bc, wc);
      chk($sformatf("v%0d_fail", v), 32'(fail), 32'(vecs[v].e_fail));
      chk($sformatf("v%0d_fail_addr", v), 32'(fail_addr), 32'(vecs[v].e_addr));
      chk($sformatf("v%0d_fail_elem", v), 32'(fail_elem), 32'(vecs[v].e_elem));
`ifdef MBIST_CKBD_EN
      chk($sformatf("v%0d_fail_pass", v), 32'(fail_pass), 32'd0);
`endif
      chk($sformatf("v%0d_done_cycle", v), dc, DONE_CYC);
      chk($sformatf("v%0d_done_count", v), dn, 1);
      chk($sformatf("v%0d_busy_cycles", v), bc, DONE_CYC);
      chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);

      if (v == 0) begin
        chk("write_count", wc, WR_CNT);
        terr = 0;
        for (int m = 0; m < 160; m++) begin
          if (tr_wr[m+2] !== ex_wr[m] || tr_addr[m+2] !== ex_addr[m]) terr++;
          if (ex_wr[m] && tr_wd[m+1] !== ex_wd[m]) terr++;
        end
        chk("op_trace_errors", terr, 0);
        chk("preload", 32'({tr_wr[1], tr_addr[1], tr_wd[1]}), 32'd0);
        chk("e3_first_read", 32'({tr_wr[82], tr_addr[82]}), 32'({1'b0, 4'd15}));
        chk("e3_second_read_addr", 32'(tr_addr[84]), 32'd14);
        chk("e3_last_addr", 32'(tr_addr[113]), 32'd0);
        chk("e1_write_wdata", 32'(tr_wd[18]), 32'h0FF);
        chk("drain_reads", 32'({tr_wr[162], tr_wr[163]}), 32'd0);
        chk("drain_addr_held", 32'(tr_addr[163]), 32'd15);
`ifdef MBIST_CKBD_EN
        chk("ckbd_preload_wdata", 32'(tr_wd[164]), 32'h055);
        chk("ckbd_first_op", 32'({tr_wr[165], tr_addr[165]}), 32'({1'b1, 4'd0}));
`endif
      end
    end

    // Abort mid-run: reset sampled at the end of cycle 50.
    set_faults(5, 8'h01, 8'h00, -1, 8'h00, 8'h00);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 35) chk("abort_fail_before_reset", 32'(fail), 32'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", 32'({busy, done, fail}), 32'd0);
    chk("abort_fail_loc", 32'({fail_addr, fail_elem}), 32'd0);
    chk("abort_mem_if", 32'({mem_write_read, mem_address, mem_wdata}), 32'd0);
    rst_n = 1'b1;
    dn = 0;
    busy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) busy_seen++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_stays_idle", busy_seen, 0);
    chk("abort_fail_stays_clear", 32'(fail), 32'd0);

    set_faults(-1, 8'h00, 8'h00, -1, 8'h00, 8'h00);
    run_once(dc, dn, bc, wc);
    chk("post_abort_fail", 32'(fail), 32'd0);
    chk("post_abort_done_cycle", dc, DONE_CYC);
    chk("post_abort_writes", wc, WR_CNT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
